// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath types, defaults and the ReLU clamp
package cnn_pkg;

  // Default element width of conv feature-map samples.
  localparam int DATA_WIDTH_DEF = 8;

  // Working width of the clamp helper; callers sign-extend into it and
  // truncate the result back to their own element width.
  localparam int CLAMP_WIDTH = 32;

  // Lane arbitration states shared by the ReLU lane blocks.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } relu_state_t;

  // ReLU on a two's complement value: negatives (including the most
  // negative code) become zero, everything else passes through untouched.
  function automatic logic [CLAMP_WIDTH-1:0] relu_clamp(
    input logic signed [CLAMP_WIDTH-1:0] value
  );
    return value[CLAMP_WIDTH-1] ? '0 : value;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int                cand;
  logic [IDX_W-1:0]  cand_idx;

  // Walk the requesters starting just after last_grant, wrapping around,
  // and take the first one found; last_grant itself is checked last.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_req && req[cand_idx]) begin
        any_req            = 1'b1;
        grant_oh[cand_idx] = 1'b1;
        grant_idx          = cand_idx;
      end
    end
  end

endmodule

// File: rtl/relu_lane_arbiter.sv
// rtl/relu_lane_arbiter.sv - round-robin burst arbiter feeding one shared ReLU lane
module relu_lane_arbiter
  import cnn_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = 676
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_REQ)-1:0]         out_src,
  output logic                               out_last,
  output logic                               busy
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BURST_LEN - 1);
  localparam logic [SRC_W-1:0] LAST_REQ   = SRC_W'(NUM_REQ - 1);

  relu_state_t          state;
  logic [SRC_W-1:0]     grant;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [SRC_W-1:0]     last_grant;
  logic [CNT_W-1:0]     count;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [SRC_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 lane_open;
  logic                 xfer;
  logic                 at_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .any_req    (pick_any)
  );

  // The lane can take an element when a burst is granted and the output
  // register is empty or being drained this cycle.
  assign lane_open = (state == BURST) && (!out_valid || out_ready);
  assign req_ready = lane_open ? grant_oh : '0;
  assign xfer      = |(req_valid & req_ready);
  assign at_last   = (count == LAST_COUNT);
  assign busy      = (state == BURST);

  // Arbitration FSM, burst counter and the registered ReLU output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      grant_oh   <= '0;
      last_grant <= LAST_REQ;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= BURST;
            grant    <= pick_idx;
            grant_oh <= pick_oh;
            count    <= '0;
          end
        end
        BURST: begin
          // A stalled granted channel simply holds the lane; no timeout.
          if (xfer) begin
            if (at_last) begin
              count      <= '0;
              last_grant <= grant;
              state      <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
      endcase

      // A new element always wins over draining, giving bubble-free
      // handover when out_ready and a transfer coincide.
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= DATA_WIDTH'(relu_clamp(CLAMP_WIDTH'($signed(req_data[grant]))));
        out_src   <= grant;
        out_last  <= at_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_lane_arbiter.sv
// tb/tb_relu_lane_arbiter.sv - directed self-checking bench for relu_lane_arbiter
module tb_relu_lane_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [1:0]       out_src;
  logic             out_last;
  logic             busy;

  int n_checks;
  int n_fail;
  int cyc;

  logic [7:0] tbl [4][8];
  int         pos [4];
  logic [3:0] take;

  typedef struct {
    int src;
    int last;
    int data;
    int stamp;
  } obs_t;
  obs_t q[$];

  relu_lane_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .BURST_LEN  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes seen mid-cycle are the ones the next rising edge commits.
  always @(negedge clk) take = req_valid & req_ready;

  // Channel sources: advance on a consumed element, present the next one.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (take[i]) pos[i] = pos[i] + 1;
    #1;
    for (int i = 0; i < 4; i++) req_data[i] = tbl[i][pos[i] % 8];
  end

  // Output monitor records every accepted output word.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      q.push_back('{src: int'(out_src), last: int'(out_last), data: int'(out_data), stamp: cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_src"},   out_src,   0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_req_ready"}, req_ready, 0);
  endtask

  task automatic check_burst(input string tag, input int src, input int d0, input int d1,
                             input int d2, input int d3);
    int exp_d[4];
    exp_d = '{d0, d1, d2, d3};
    check({tag, "_count"}, q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < q.size()) begin
        check($sformatf("%s_src%0d", tag, j),  q[j].src,  src);
        check($sformatf("%s_data%0d", tag, j), q[j].data, exp_d[j]);
        check($sformatf("%s_last%0d", tag, j), q[j].last, (j == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int ext0[8];
    int ch;
    int k;
    ext0 = '{0, 127, 0, 5, 1, 2, 3, 4};
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b0000;
    req_data  = '0;
    take      = '0;
    tbl[0] = '{8'h80, 8'h7F, 8'hFF, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
    tbl[2] = '{8'hFB, 8'h00, 8'h07, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int j = 0; j < 8; j++) begin
      tbl[1][j] = 8'(16 + j);
      tbl[3][j] = 8'(48 + j);
    end
    for (int i = 0; i < 4; i++) pos[i] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    tick();
    rst = 1'b0;

    // Single requester ch2: -5,0,7,-1 -> 0,0,7,0
    tick();
    q.delete();
    req_valid = 4'b0100;
    @(negedge clk);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_ready", req_ready, 0);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_ready", req_ready, 4'b0100);
    check("t1_first_outv", out_valid, 0);
    repeat (4) @(posedge clk);
    #2 req_valid = 4'b0000;
    @(negedge clk);
    check("t1_end_busy", busy, 0);
    check("t1_end_last", out_last, 1);
    check("t1_end_ready", req_ready, 0);
    @(negedge clk);
    check("t1_drain_outv", out_valid, 0);
    check_burst("t1", 2, 0, 0, 7, 0);

    // Reset, then round-robin with all channels requesting (ch0 holds extremes)
    tick();
    rst = 1'b1;
    for (int j = 0; j < 8; j++) tbl[2][j] = 8'(32 + j);
    for (int i = 0; i < 4; i++) pos[i] = 0;
    tick();
    rst = 1'b0;
    tick();
    q.delete();
    req_valid = 4'b1111;
    repeat (25) @(posedge clk);
    #2 req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    check("rr_count", q.size(), 20);
    for (int b = 0; b < 5; b++) begin
      ch = b % 4;
      for (int j = 0; j < 4; j++) begin
        k = b * 4 + j;
        if (k < q.size()) begin
          check($sformatf("rr_src%0d", k),  q[k].src, ch);
          check($sformatf("rr_last%0d", k), q[k].last, (j == 3) ? 1 : 0);
          check($sformatf("rr_data%0d", k), q[k].data,
                (ch == 0) ? ext0[(b / 4) * 4 + j] : 16 * ch + j);
          check($sformatf("rr_time%0d", k), q[k].stamp - q[0].stamp, 5 * b + j);
        end
      end
    end

    // Backpressure mid-burst on ch1: output held, nothing lost or repeated
    tick();
    for (int j = 0; j < 4; j++) tbl[1][j] = 8'(10 + j);
    pos[1] = 0;
    tick();
    q.delete();
    req_valid = 4'b0010;
    repeat (3) @(posedge clk);
    #2 out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("bp_outv%0d", s),  out_valid, 1);
      check($sformatf("bp_data%0d", s),  out_data, 11);
      check($sformatf("bp_ready%0d", s), req_ready, 0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    check_burst("bp", 1, 10, 11, 12, 13);

    // Reset after the second element of a ch1 burst
    tick();
    for (int j = 0; j < 4; j++) tbl[1][j] = 8'(20 + j);
    pos[1] = 0;
    tick();
    req_valid = 4'b0010;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mr_pre_data", out_data, 21);
    check("mr_pre_src", out_src, 1);
    @(negedge clk);
    check_reset_vals("mr");
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    check("mr_idle_busy", busy, 0);
    @(negedge clk);
    check("mr_regrant_busy", busy, 1);
    check("mr_regrant_ready", req_ready, 4'b0001);
    repeat (4) @(posedge clk);
    #2 req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    check("mr_done_busy", busy, 0);

    // Granted ch3 stalls for 5 cycles while ch0 requests
    tick();
    for (int j = 0; j < 4; j++) tbl[3][j] = 8'(60 + j);
    pos[3] = 0;
    tick();
    q.delete();
    req_valid = 4'b1000;
    @(posedge clk);
    #2 req_valid = 4'b1001;
    repeat (2) @(posedge clk);
    #2 req_valid = 4'b0001;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("st_busy%0d", s),  busy, 1);
      check($sformatf("st_ready%0d", s), req_ready, 4'b1000);
    end
    @(posedge clk);
    #2 req_valid = 4'b1001;
    repeat (2) @(posedge clk);
    #2 req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    check("st_end_busy", busy, 0);
    check_burst("st", 3, 60, 61, 62, 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
